// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button gesture decoder:
//   - 3-bit state encodings for the gesture FSM and the matching enum type
//   - default cycle counts for a 25 MHz board clock
//   - small helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package button_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS1    = 3'd1;
  localparam logic [2:0] ST_WAIT_GAP  = 3'd2;
  localparam logic [2:0] ST_PRESS2    = 3'd3;
  localparam logic [2:0] ST_LONG_HELD = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    PRESS1    = ST_PRESS1,
    WAIT_GAP  = ST_WAIT_GAP,
    PRESS2    = ST_PRESS2,
    LONG_HELD = ST_LONG_HELD
  } gesture_state_t;

  // 0.5 s and 0.25 s at 25 MHz
  localparam int LONG_PRESS_25MHZ = 12_500_000;
  localparam int DOUBLE_GAP_25MHZ = 6_250_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_edge_detect.sv
// ---------------------------------------------------------------------------
// button_edge_detect
// Registers the debounced button level and derives its edges.
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   level          : debounced button level, 1 = pressed
//   rise / fall    : combinational edge indications for the gesture FSM
//   press_strobe   : registered one-cycle strobe on each 0->1 edge
//   release_strobe : registered one-cycle strobe on each 1->0 edge
// ---------------------------------------------------------------------------
module button_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise,
  output logic fall,
  output logic press_strobe,
  output logic release_strobe
);

  logic r_Prev;

  // r_Prev resets to 0, so a button held through reset is seen as a fresh
  // press on the first cycle after reset is released.
  assign rise = level & ~r_Prev;
  assign fall = ~level & r_Prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_Prev         <= 1'b0;
      press_strobe   <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      r_Prev         <= level;
      press_strobe   <= rise;
      release_strobe <= fall;
    end
  end

endmodule

// File: rtl/button_gesture_decoder.sv
// ---------------------------------------------------------------------------
// button_gesture_decoder
// Turns a debounced button level into one-cycle gesture events.
//   i_Clk       : system clock
//   i_Rst_L     : asynchronous active-low reset
//   i_Debounced : debounced switch level, 1 = pressed
//   o_Press     : strobe on each press edge
//   o_Release   : strobe on each release edge
//   o_Short     : strobe for a single click (no second press within the gap)
//   o_Long      : strobe when a press lasts LONG_PRESS_CYCLES
//   o_Double    : strobe on release of the second press of a double click
//   o_Held      : level, high while a long press is still held
// All outputs are registered; strobes appear one cycle after the sampled
// edge or FSM decision that causes them.
// ---------------------------------------------------------------------------
module button_gesture_decoder
  import button_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_25MHZ,
  parameter int DOUBLE_GAP_CYCLES = DOUBLE_GAP_25MHZ
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Debounced,
  output logic o_Press,
  output logic o_Release,
  output logic o_Short,
  output logic o_Long,
  output logic o_Double,
  output logic o_Held
);

  localparam int CNT_W = $clog2(max_int(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES));
  localparam logic [CNT_W-1:0] LONG_LIMIT = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIMIT  = CNT_W'(DOUBLE_GAP_CYCLES - 1);

  gesture_state_t   state, next_state;
  logic [CNT_W-1:0] r_Count, count_next;
  logic             rise, fall;
  logic             short_next, long_next, double_next, held_next;

  button_edge_detect u_edge (
    .clk            (i_Clk),
    .rst_n          (i_Rst_L),
    .level          (i_Debounced),
    .rise           (rise),
    .fall           (fall),
    .press_strobe   (o_Press),
    .release_strobe (o_Release)
  );

  // State, shared counter and registered gesture outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state    <= IDLE;
      r_Count  <= '0;
      o_Short  <= 1'b0;
      o_Long   <= 1'b0;
      o_Double <= 1'b0;
      o_Held   <= 1'b0;
    end else begin
      state    <= next_state;
      r_Count  <= count_next;
      o_Short  <= short_next;
      o_Long   <= long_next;
      o_Double <= double_next;
      o_Held   <= held_next;
    end
  end

  // Next-state logic. Edges are checked before the counter limits so that
  // a release on the long-limit cycle and a press on the gap-limit cycle
  // both take precedence over the timeout. Every transition clears the
  // counter; states that do not time anything simply hold it at zero.
  always_comb begin
    next_state  = state;
    count_next  = r_Count + CNT_W'(1);
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state)
      IDLE: begin
        count_next = '0;
        if (rise) next_state = PRESS1;
      end
      PRESS1: begin
        if (fall) begin
          next_state = WAIT_GAP;
          count_next = '0;
        end else if (r_Count == LONG_LIMIT) begin
          next_state = LONG_HELD;
          count_next = '0;
          long_next  = 1'b1;
        end
      end
      WAIT_GAP: begin
        if (rise) begin
          next_state = PRESS2;
          count_next = '0;
        end else if (r_Count == GAP_LIMIT) begin
          next_state = IDLE;
          count_next = '0;
          short_next = 1'b1;
        end
      end
      PRESS2: begin
        count_next = '0;
        if (fall) begin
          next_state  = IDLE;
          double_next = 1'b1;
        end
      end
      LONG_HELD: begin
        count_next = '0;
        if (fall) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        count_next = '0;
      end
    endcase
    held_next = (next_state == LONG_HELD);
  end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// ---------------------------------------------------------------------------
// tb_button_gesture_decoder
// Self-checking bench for button_gesture_decoder with LONG_PRESS_CYCLES=8
// and DOUBLE_GAP_CYCLES=4. Output vectors are packed as
// {o_Press, o_Release, o_Short, o_Long, o_Double, o_Held}.
// ---------------------------------------------------------------------------
module tb_button_gesture_decoder;

  localparam int LP = 8;
  localparam int DG = 4;

  logic i_Clk = 1'b0;
  logic i_Rst_L;
  logic i_Debounced;
  logic o_Press, o_Release, o_Short, o_Long, o_Double, o_Held;

  int checks = 0;
  int errors = 0;

  // Reference model: tracks how many presses the current gesture has seen,
  // when its last edge happened and whether it already became a long press.
  bit         m_prev;
  int         m_presses;
  bit         m_long;
  int         m_t;
  int         m_edge_t;
  logic [5:0] m_exp;

  typedef struct {
    bit         d;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  button_gesture_decoder #(
    .LONG_PRESS_CYCLES (LP),
    .DOUBLE_GAP_CYCLES (DG)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Debounced (i_Debounced),
    .o_Press     (o_Press),
    .o_Release   (o_Release),
    .o_Short     (o_Short),
    .o_Long      (o_Long),
    .o_Double    (o_Double),
    .o_Held      (o_Held)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [5:0] outs();
    return {o_Press, o_Release, o_Short, o_Long, o_Double, o_Held};
  endfunction

  task automatic modelReset();
    m_prev    = 1'b0;
    m_presses = 0;
    m_long    = 1'b0;
    m_exp     = 6'b0;
  endtask

  task automatic modelStep(input bit d);
    bit rise, fall, s, l, db;
    rise = d & ~m_prev;
    fall = ~d & m_prev;
    s = 1'b0; l = 1'b0; db = 1'b0;
    m_t++;
    if (rise) begin
      if (m_presses == 0) begin
        m_presses = 1;
        m_edge_t  = m_t;
      end else if (m_presses == 1) begin
        m_presses = 2;
      end
    end else if (fall) begin
      if (m_presses == 2) begin
        db = 1'b1;
        m_presses = 0;
      end else if (m_long) begin
        m_long    = 1'b0;
        m_presses = 0;
      end else if (m_presses == 1) begin
        m_edge_t = m_t;
      end
    end else if (m_presses == 1 && !m_long) begin
      if (d && (m_t - m_edge_t == LP)) begin
        l = 1'b1;
        m_long = 1'b1;
      end else if (!d && (m_t - m_edge_t == DG)) begin
        s = 1'b1;
        m_presses = 0;
      end
    end
    m_exp  = {rise, fall, s, l, db, m_long};
    m_prev = d;
  endtask

  // Drive one input sample and leave time just after the sampling edge.
  task automatic applyStimulus(input bit d);
    @(negedge i_Clk);
    i_Debounced = d;
    modelStep(d);
    @(posedge i_Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b required %b", name, $time, outs(), exp);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic stepModel(input string name, input bit d);
    applyStimulus(d);
    checkOutput(name, m_exp);
  endtask

  // Assert reset between edges, verify it clears outputs at once, and
  // release it just after a rising edge so the next sample is modelled.
  task automatic doReset(input string name, input bit d);
    @(negedge i_Clk);
    i_Debounced = d;
    i_Rst_L = 1'b0;
    #1;
    checkOutput(name, 6'b0);
    modelReset();
    @(posedge i_Clk);
    @(posedge i_Clk);
    #2;
    i_Rst_L = 1'b1;
  endtask

  initial begin
    int press_i, long_i, held_n, short_n;
    i_Rst_L     = 1'b0;
    i_Debounced = 1'b0;
    m_t         = 0;
    m_edge_t    = 0;
    modelReset();
    #1;
    checkOutput("reset_hold", 6'b0);
    doReset("reset_initial", 1'b0);

    for (int i = 0; i < 20; i++) stepModel("idle", 1'b0);

    // Short click: press 3 cycles, release, short follows 4 cycles later.
    tbl.push_back('{1'b1, 6'b100000});
    tbl.push_back('{1'b1, 6'b000000});
    tbl.push_back('{1'b1, 6'b000000});
    tbl.push_back('{1'b0, 6'b010000});
    tbl.push_back('{1'b0, 6'b000000});
    tbl.push_back('{1'b0, 6'b000000});
    tbl.push_back('{1'b0, 6'b000000});
    tbl.push_back('{1'b0, 6'b001000});
    tbl.push_back('{1'b0, 6'b000000});
    // Double click: 2 on, 2 off, 2 on, release -> double with 2nd release.
    tbl.push_back('{1'b1, 6'b100000});
    tbl.push_back('{1'b1, 6'b000000});
    tbl.push_back('{1'b0, 6'b010000});
    tbl.push_back('{1'b0, 6'b000000});
    tbl.push_back('{1'b1, 6'b100000});
    tbl.push_back('{1'b1, 6'b000000});
    tbl.push_back('{1'b0, 6'b010010});
    for (int i = 0; i < 6; i++) tbl.push_back('{1'b0, 6'b000000});
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].d);
      checkOutput($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Long press held 20 cycles.
    press_i = -1; long_i = -1; held_n = 0; short_n = 0;
    for (int i = 0; i < 30; i++) begin
      stepModel("long_press", (i < 20));
      if (o_Press) press_i = i;
      if (o_Long) long_i = i;
      if (o_Held) held_n++;
      if (o_Short) short_n++;
    end
    checkInt("long_latency", long_i - press_i, LP);
    checkInt("held_cycles", held_n, 20 - LP);
    checkInt("long_no_short", short_n, 0);

    // Release on the long-limit cycle: no long, short 4 cycles after release.
    for (int i = 0; i < LP; i++) stepModel("fall_on_limit", 1'b1);
    for (int i = 0; i < 10; i++) stepModel("fall_on_limit", 1'b0);

    // Second press on the gap-limit cycle: becomes a double click.
    for (int i = 0; i < 2; i++) stepModel("rise_on_limit", 1'b1);
    for (int i = 0; i < DG; i++) stepModel("rise_on_limit", 1'b0);
    for (int i = 0; i < 2; i++) stepModel("rise_on_limit", 1'b1);
    applyStimulus(1'b0);
    checkOutput("rise_on_limit_double", 6'b010010);
    for (int i = 0; i < 8; i++) stepModel("rise_on_limit", 1'b0);

    // Reset two cycles into the gap: the pending short is discarded.
    for (int i = 0; i < 2; i++) stepModel("reset_mid_gap", 1'b1);
    for (int i = 0; i < 3; i++) stepModel("reset_mid_gap", 1'b0);
    doReset("reset_mid_gap_async", 1'b0);
    short_n = 0;
    for (int i = 0; i < 12; i++) begin
      stepModel("after_reset", 1'b0);
      if (o_Short) short_n++;
    end
    checkInt("reset_mid_gap_no_short", short_n, 0);

    // Button held through reset shows up as a press right after reset.
    doReset("reset_held", 1'b1);
    applyStimulus(1'b1);
    checkOutput("held_through_reset", 6'b100000);
    for (int i = 0; i < 12; i++) stepModel("held_through_reset", 1'b0);

    // Randomised runs of pressed/released levels with occasional resets.
    for (int r = 0; r < 400; r++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 40) == 0) doReset("random_reset", lvl);
      for (int i = 0; i < len; i++) stepModel("random", lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_gesture_decoder.md
# button_gesture_decoder

Classifies a debounced push-button level into one-cycle gesture events: short click, long press and double click. It also produces raw press/release strobes and a long-hold level. It sits directly downstream of the switch debounce filter, consuming its clean level, and drives LED/UI control logic. It is fully synchronous to the board clock and holds no combinational input-to-output paths.

## Interface

**Parameters**

- `LONG_PRESS_CYCLES`, default 12_500_000 (0.5 s at 25 MHz). Cycles of continuous press before `o_Long` fires. Legal range ≥ 2.
- `DOUBLE_GAP_CYCLES`, default 6_250_000 (0.25 s at 25 MHz). Maximum release gap for a second press to form a double click. Legal range ≥ 2.

**Ports**

- `i_Clk`, input, 1 bit: system clock. Reset is asynchronous and active-low.
- `i_Rst_L`, input, 1 bit: asynchronous active-low reset.
- `i_Debounced`, input, 1 bit: debounced switch level, 1 = pressed. Already synchronous to `i_Clk`.
- `o_Press`, output, 1 bit: one-cycle strobe on each 0→1 input edge.
- `o_Release`, output, 1 bit: one-cycle strobe on each 1→0 input edge.
- `o_Short`, output, 1 bit: one-cycle strobe for a single click (press, release, no second press within the gap).
- `o_Long`, output, 1 bit: one-cycle strobe when a press reaches `LONG_PRESS_CYCLES`.
- `o_Double`, output, 1 bit: one-cycle strobe on release of the second press of a double click.
- `o_Held`, output, 1 bit: level, high while in LONG_HELD.

## Operation

- **Edge detect:** `r_Prev` registers `i_Debounced`.
  - rise = `i_Debounced & ~r_Prev`
  - fall = `~i_Debounced & r_Prev`
- **Counter:** one shared down-counter-free up-counter `r_Count`.
  - Width is `$clog2(max(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES))`.
  - Cleared on every state entry. Never wraps: it cannot exceed its limit minus 1 before a transition.
- **States:**
  - **IDLE:** rise → PRESS1.
  - **PRESS1:**
    - fall → WAIT_GAP.
    - Else if `r_Count == LONG_PRESS_CYCLES-1` → LONG_HELD and pulse `o_Long`.
    - Else increment.
  - **WAIT_GAP:**
    - rise → PRESS2.
    - Else if `r_Count == DOUBLE_GAP_CYCLES-1` → IDLE and pulse `o_Short`.
    - Else increment.
  - **PRESS2:** fall → IDLE and pulse `o_Double`. No long-press detection in this state.
  - **LONG_HELD:** fall → IDLE. No gesture strobe.
- **Simultaneous events:**
  - Fall on the long-limit cycle: fall wins (WAIT_GAP, no `o_Long`).
  - Rise on the gap-limit cycle: rise wins (PRESS2, no `o_Short`).
- **Strobe independence:** `o_Press` and `o_Release` fire on every edge regardless of state, including both presses of a double click.
- **Mutual exclusion:** at most one of `o_Short`, `o_Long`, `o_Double` is high in any cycle.

## Timing

- **Registered outputs:** all outputs are registered.
  - An edge sampled in cycle k produces its strobe in cycle k+1.
  - A state transition decided in cycle k produces its gesture strobe in cycle k+1.
- **`o_Long`:** exactly `LONG_PRESS_CYCLES` cycles after the `o_Press` that started PRESS1.
- **`o_Short`:** exactly `DOUBLE_GAP_CYCLES` cycles after `o_Release`.
- **`o_Double`:** same cycle as the second `o_Release`.
- **`o_Held`:**
  - Rises in the same cycle as `o_Long`.
  - Falls in the same cycle as the matching `o_Release`.
- **Reset:** asserting `i_Rst_L` low immediately and asynchronously forces the following, regardless of state:
  - state = IDLE
  - `r_Count` = 0
  - `r_Prev` = 0
  - all outputs = 0
- **Reset mid-gesture:** any pending gesture is discarded.
- **Button held through reset:** it is seen as a rise on the first post-reset cycle, giving `o_Press` one cycle later.

## Structure

- **Package `button_pkg`** holds:
  - the 3-bit state encoding localparams (IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD);
  - default cycle constants for 25 MHz (`LONG_PRESS_25MHZ`, `DOUBLE_GAP_25MHZ`).
- **Sub-module `button_edge_detect`** is natural. It contains the `r_Prev` register and the registered `o_Press`/`o_Release` strobes, and exports the combinational rise/fall to the FSM.
- **Top file:** the FSM and counter live in `button_gesture_decoder`.

## Test plan

All scenarios use `LONG_PRESS_CYCLES=8`, `DOUBLE_GAP_CYCLES=4`.

- **Reset:** hold `i_Rst_L`=0 with `i_Debounced`=0 → all outputs 0. Release reset and idle 20 cycles → no strobes.
- **Short click:** press 3 cycles, release.
  - `o_Press` 1 cycle after rise.
  - `o_Release` 1 cycle after fall.
  - `o_Short` exactly 4 cycles after `o_Release`.
  - No `o_Long` or `o_Double`.
- **Long press:** hold 20 cycles.
  - `o_Long` exactly 8 cycles after `o_Press`.
  - `o_Held` high from that cycle through `o_Release`, then 0.
  - No `o_Short` afterwards.
- **Double click:** press 2 cycles, release 2 cycles, press 2 cycles, release.
  - Two `o_Press` and two `o_Release` strobes.
  - `o_Double` coincident with the second `o_Release`.
  - No `o_Short`.
- **Boundary cases:**
  - Fall on the `r_Count`=7 cycle of PRESS1 → no `o_Long`; `o_Short` follows 4 cycles after release.
  - Rise on the `r_Count`=3 cycle of WAIT_GAP → `o_Double` on the next release.
- **Reset mid-gap:** assert reset 2 cycles into WAIT_GAP → outputs 0 immediately; after deassert, no `o_Short` ever appears.
